// File: rtl/histo_pkg.sv
// Shared definitions for the histogram-equalization pipeline: FSM state
// encoding and default frame geometry, used by the CDF builder and the
// equalizer stage.
package histo_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int NUM_LEVELS   = 2 ** DATA_WIDTH;
    localparam int FRAME_PIXELS = 640 * 480;
    localparam int HISTO_WIDTH  = $clog2(FRAME_PIXELS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } histo_state_t;

endpackage

// File: rtl/histo_cdf_builder.sv
// Histogram / CDF builder. Accumulates one frame of pixels into per-level
// bins, then scans the bins one level per cycle to build the cumulative
// histogram and the minimum non-zero CDF value, and finally pulses
// start_equalization for one cycle.
//
// Pixel handshake: a pixel is transferred in a cycle where pixel_in_valid
// and pixel_in_ready are both high at the rising clock edge and frame_start
// is low. pixel_in_ready is high only in ACCUM; valid outside ACCUM is
// ignored, and a pixel offered together with frame_start is discarded.
module histo_cdf_builder
    import histo_pkg::*;
#(
    parameter int DataWidth      = DATA_WIDTH,
    parameter int NumberOfLevels = 2 ** DataWidth,
    parameter int HistoWidth     = HISTO_WIDTH,
    parameter int FramePixels    = FRAME_PIXELS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 frame_start,
    input  logic                                 pixel_in_valid,
    input  logic [DataWidth-1:0]                 pixel_in,
    output logic                                 pixel_in_ready,
    output logic [HistoWidth*NumberOfLevels-1:0] cumulative_histo_data,
    output logic [HistoWidth-1:0]                min_cumulative_histo,
    output logic                                 start_equalization,
    output logic                                 busy,
    output histo_state_t                         debug_state
);

    localparam int CntWidth = $clog2(FramePixels + 1);

    localparam logic [CntWidth-1:0]   CntOne    = CntWidth'(1);
    localparam logic [CntWidth-1:0]   CntFrame  = CntWidth'(FramePixels);
    localparam logic [HistoWidth-1:0] HistoOne  = HistoWidth'(1);
    localparam logic [DataWidth-1:0]  LastLevel = DataWidth'(NumberOfLevels - 1);

    histo_state_t          r_state;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_pulse;
    logic [CntWidth-1:0]   r_pix_cnt;
    logic [DataWidth-1:0]  r_scan_idx;
    logic [HistoWidth-1:0] r_sum;
    logic                  r_min_found;
    logic [HistoWidth-1:0] r_min;
    logic [HistoWidth-1:0] r_bins [NumberOfLevels];
    logic [HistoWidth-1:0] r_cdf  [NumberOfLevels];

    logic                  w_xfer;
    logic [CntWidth-1:0]   w_cnt_next;
    logic [HistoWidth-1:0] w_scan_bin;
    logic [HistoWidth-1:0] w_cdf_next;

    // ready is only ever high in ACCUM, so it alone qualifies a transfer
    assign w_xfer     = pixel_in_valid && r_ready && !frame_start;
    assign w_cnt_next = r_pix_cnt + CntOne;
    assign w_scan_bin = r_bins[r_scan_idx];
    assign w_cdf_next = r_sum + w_scan_bin;

    // Control FSM with registered outputs; frame_start beats every other event
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_pulse     <= 1'b0;
            r_pix_cnt   <= '0;
            r_scan_idx  <= '0;
            r_sum       <= '0;
            r_min_found <= 1'b0;
        end else if (frame_start) begin
            r_state     <= ACCUM;
            r_ready     <= 1'b1;
            r_busy      <= 1'b1;
            r_pulse     <= 1'b0;
            r_pix_cnt   <= '0;
            r_scan_idx  <= '0;
            r_sum       <= '0;
            r_min_found <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_pulse <= 1'b0;
                end
                ACCUM: begin
                    if (w_xfer) begin
                        r_pix_cnt <= w_cnt_next;
                        if (w_cnt_next == CntFrame) begin
                            r_state     <= SCAN;
                            r_ready     <= 1'b0;
                            r_scan_idx  <= '0;
                            r_sum       <= '0;
                            r_min_found <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    r_sum <= w_cdf_next;
                    if (!r_min_found && (w_cdf_next != '0)) begin
                        r_min_found <= 1'b1;
                    end
                    if (r_scan_idx == LastLevel) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_pulse <= 1'b1;
                    end else begin
                        r_scan_idx <= r_scan_idx + DataWidth'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_pulse <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_pulse <= 1'b0;
                end
            endcase
        end
    end

    // Bin array: cleared by reset or a new frame, bumped on each transfer
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            for (int i = 0; i < NumberOfLevels; i++) begin
                r_bins[i] <= '0;
            end
        end else if (w_xfer) begin
            r_bins[pixel_in] <= r_bins[pixel_in] + HistoOne;
        end
    end

    // CDF entries and min: one entry written per SCAN cycle, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumberOfLevels; i++) begin
                r_cdf[i] <= '0;
            end
            r_min <= '0;
        end else if (!frame_start && (r_state == SCAN)) begin
            r_cdf[r_scan_idx] <= w_cdf_next;
            // running sum is still zero here, so this equals the bin count
            if (!r_min_found && (w_cdf_next != '0)) begin
                r_min <= w_cdf_next;
            end
        end
    end

    for (genvar g = 0; g < NumberOfLevels; g++) begin : g_cdf_bus
        assign cumulative_histo_data[g*HistoWidth +: HistoWidth] = r_cdf[g];
    end

    assign pixel_in_ready       = r_ready;
    assign busy                 = r_busy;
    assign start_equalization   = r_pulse;
    assign min_cumulative_histo = r_min;
    assign debug_state          = r_state;

endmodule

// File: doc/histo_cdf_builder.md
Name: histo_cdf_builder

Overview:
Upstream stage of the histogram-equalization pipeline. Accumulates a per-level pixel histogram over one frame of streamed pixels, then serially scans the bins to build the cumulative histogram (CDF). Presents the CDF as a flat bus together with the minimum non-zero CDF value. Issues a one-cycle start pulse to the equalizer stage when both are valid.

Parameters:
DataWidth, 8, pixel bit width
NumberOfLevels, 256, number of grey levels (2**DataWidth)
HistoWidth, $clog2(640*480) = 19, width of each bin/CDF entry
FramePixels, 640*480, pixels per frame; must be ≤ 2**HistoWidth - 1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
frame_start  in  1  one-cycle pulse: clear histogram, begin accumulating a new frame
pixel_in_valid  in  1  pixel_in carries a pixel
pixel_in  in  DataWidth  pixel grey level
pixel_in_ready  out  1  block accepts pixels; transfer = valid && ready
cumulative_histo_data  out  HistoWidth*NumberOfLevels  CDF; entry i at [i*HistoWidth +: HistoWidth]
min_cumulative_histo  out  HistoWidth  first non-zero CDF entry
start_equalization  out  1  one-cycle pulse; CDF and min are complete and stable
busy  out  1  high in ACCUM or SCAN

Behaviour:
- Reset: state IDLE. All outputs 0: ready, busy, pulse, CDF bus, min. All bins 0, pixel counter 0.
- States: IDLE, ACCUM, SCAN, DONE.
- IDLE: ready=0. On frame_start: clear all bins and pixel counter in one cycle, go to ACCUM.
- ACCUM: ready=1. Each transfer increments bin[pixel_in] by 1 and the pixel counter by 1.
- ACCUM exit: when the transfer that makes count == FramePixels occurs, go to SCAN; ready is 0 from the next cycle.
- Pixel counter width: $clog2(FramePixels+1). Bins never overflow, given the FramePixels constraint.
- SCAN: index i runs 0..NumberOfLevels-1, one level per cycle.
  - running_sum += bin[i]; CDF entry i <= running_sum + bin[i].
  - min is captured at the first i with non-zero CDF. The captured value equals bin[i] at that level.
- SCAN writes only entry i each cycle. The bus holds the previous frame's CDF until overwritten; downstream uses it only after the pulse.
- After i = NumberOfLevels-1: go to DONE.
- DONE: start_equalization=1 for exactly one cycle, then IDLE. CDF bus and min hold until the next SCAN.
- Latency: last pixel accepted in cycle T; SCAN covers T+1..T+NumberOfLevels; pulse in T+NumberOfLevels+1.
- frame_start in ACCUM, SCAN or DONE: abort the current frame.
  - Clear bins, counter, running sum and min-found flag; go to ACCUM.
  - No pulse for the aborted frame.
  - A pixel presented in the frame_start cycle is discarded, even if ready=1.
- frame_start has priority over every other event in the same cycle.
- pixel_in_valid outside ACCUM is ignored.
- rst mid-operation: immediate return to reset values; no pulse.
- All arithmetic is unsigned; sum width is HistoWidth.

Decomposition:
- Shared package histo_pkg:
  - state typedef (IDLE/ACCUM/SCAN/DONE);
  - default constants DATA_WIDTH, NUM_LEVELS, HISTO_WIDTH, FRAME_PIXELS;
  - shared with the equalizer stage.
- No sub-module is required. The bin array is a register array inside this block.

Test Plan:
- Reset: hold rst 3 cycles with pixel_in_valid=1 -> ready=0, busy=0, pulse=0, CDF bus=0, min=0.
- FramePixels=16; frame_start, then 16 back-to-back pixels of value 5 -> CDF[0..4]=0, CDF[5..255]=16, min=16. Pulse exactly 257 cycles after the last accept.
- FramePixels=16; pixels 0..15 once each with random valid gaps -> CDF[i]=i+1 for i<16, CDF[16..255]=16, min=1. Ready=0 from the cycle after the 16th accept.
- Abort: 5 pixels of value 9, then frame_start asserted with valid=1 and pixel value 9, then 16 pixels of value 2 -> CDF[0..1]=0, CDF[2..255]=16, min=16, exactly one pulse.
- rst asserted at scan index 100 -> outputs return to 0 and no pulse. A fresh frame_start plus 16 pixels of 0 gives CDF[all]=16, min=16.
- Back-to-back frames: frame 1 all value 255, frame 2 all value 0 -> after the second pulse CDF[all]=16, min=16. Bus holds frame 1 values until overwritten during SCAN.
